// File: rtl/write_nanofs_pkg.sv
// Shared nanofs on-card format constants and the writer state encoding.
// The reader imports the same header layout from here.
package nanofs_pkg;

    localparam int unsigned NANOFS_BLOCK_BYTES       = 512;
    localparam int unsigned NANOFS_HDR_BYTES         = 8;
    localparam int unsigned NANOFS_HDR_NEXT_DIR_OFF  = 0;
    localparam int unsigned NANOFS_HDR_BLOCK_LEN_OFF = 4;
    localparam logic [31:0] NANOFS_NEXT_DIR_NONE     = 32'h0;

    typedef enum logic [4:0] {
        ST_IDLE,
        ST_WAIT_READY,
        ST_OPEN,
        ST_WAIT_OPEN,
        ST_HDR,
        ST_WAIT_HDR,
        ST_CHECK,
        ST_DATA_REQ,
        ST_WAIT_DATA,
        ST_PAD,
        ST_WAIT_PAD,
        ST_CLOSE,
        ST_WAIT_CLOSE,
        ST_FINISH,
        ST_ERROR
    } nanofs_wr_state_e;

endpackage

// File: rtl/write_nanofs_if.sv
// Sector-write link between the nanofs writer and the SPI SD controller.
interface write_nanofs_if;

    logic        spi_w_block;
    logic        spi_w_byte;
    logic [7:0]  spi_data_in;
    logic [31:0] spi_block_addr;
    logic        spi_busy;
    logic        spi_err;

    modport master (
        output spi_w_block, spi_w_byte, spi_data_in, spi_block_addr,
        input  spi_busy, spi_err
    );

    modport slave (
        input  spi_w_block, spi_w_byte, spi_data_in, spi_block_addr,
        output spi_busy, spi_err
    );

endinterface

// File: rtl/write_nanofs_hdr_mux.sv
// Selects one byte of the 8-byte segment header {next_dir LE, block_len LE}.
module nanofs_hdr_mux
    import nanofs_pkg::*;
(
    input  logic [31:0] next_dir_i,
    input  logic [31:0] block_len_i,
    input  logic [2:0]  idx_i,
    output logic [7:0]  byte_o
);

    logic [NANOFS_HDR_BYTES*8-1:0] hdr;

    always_comb begin
        hdr = '0;
        hdr[NANOFS_HDR_NEXT_DIR_OFF*8 +: 32]  = next_dir_i;
        hdr[NANOFS_HDR_BLOCK_LEN_OFF*8 +: 32] = block_len_i;
    end

    assign byte_o = hdr[{idx_i, 3'b000} +: 8];

endmodule

// File: rtl/write_nanofs.sv
// nanofs writer: streams one file segment (header + payload + zero pad)
// onto consecutive SD sectors through the controller's sector-write link.
module write_nanofs
    import nanofs_pkg::*;
#(
    parameter int unsigned BLOCK_BYTES = NANOFS_BLOCK_BYTES,
    parameter int unsigned HDR_BYTES   = NANOFS_HDR_BYTES
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic [31:0]   offset_i,
    input  logic [31:0]   begin_address_i,
    input  logic [31:0]   file_len_i,
    input  logic          wr_byte_i,
    input  logic [7:0]    byte_data_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          error_o,
    write_nanofs_if.master spi
);

    localparam int unsigned CW = $clog2(BLOCK_BYTES + 1);

    nanofs_wr_state_e state_q, state_d;
    logic [CW-1:0] byte_cnt_q, byte_cnt_d;
    logic [31:0]   prog_cnt_q, prog_cnt_d;
    logic [31:0]   file_len_q, file_len_d;
    logic [31:0]   addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic          w_block_q, w_block_d, w_byte_q, w_byte_d;
    logic [7:0]    hdr_byte;
    logic          all_sent, sec_full, hdr_left, take_start;

    assign all_sent   = (prog_cnt_q == file_len_q);
    assign sec_full   = (byte_cnt_q == CW'(BLOCK_BYTES));
    assign hdr_left   = (byte_cnt_q < CW'(HDR_BYTES));
    assign take_start = start_i && (state_q inside {ST_IDLE, ST_FINISH, ST_ERROR});

    nanofs_hdr_mux u_hdr_mux (
        .next_dir_i  (NANOFS_NEXT_DIR_NONE),
        .block_len_i (file_len_q),
        .idx_i       (byte_cnt_q[2:0]),
        .byte_o      (hdr_byte)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Only payload-free sectors carry no data, so prog_cnt==0 marks sector 0.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:       if (start_i) state_d = ST_WAIT_READY;
            ST_WAIT_READY: if (!spi.spi_busy) state_d = ST_OPEN;
            ST_OPEN:       state_d = ST_WAIT_OPEN;
            ST_WAIT_OPEN:  if (!spi.spi_busy) state_d = (prog_cnt_q == '0) ? ST_HDR : ST_DATA_REQ;
            ST_HDR:        state_d = ST_WAIT_HDR;
            ST_WAIT_HDR:   if (!spi.spi_busy) state_d = hdr_left ? ST_HDR : ST_CHECK;
            ST_CHECK:      state_d = all_sent ? ST_PAD : (sec_full ? ST_CLOSE : ST_DATA_REQ);
            ST_DATA_REQ:   if (wr_byte_i) state_d = ST_WAIT_DATA;
            ST_WAIT_DATA:  if (!spi.spi_busy) state_d = ST_CHECK;
            ST_PAD:        state_d = sec_full ? ST_CLOSE : ST_WAIT_PAD;
            ST_WAIT_PAD:   if (!spi.spi_busy) state_d = ST_PAD;
            ST_CLOSE:      state_d = ST_WAIT_CLOSE;
            ST_WAIT_CLOSE: if (!spi.spi_busy) state_d = all_sent ? ST_FINISH : ST_OPEN;
            ST_FINISH,
            ST_ERROR:      if (start_i) state_d = ST_WAIT_READY;
            default:       state_d = ST_IDLE;
        endcase
        if (spi.spi_err && state_q != ST_IDLE && !take_start) state_d = ST_ERROR;
    end

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        prog_cnt_d = prog_cnt_q;
        file_len_d = file_len_q;
        addr_d     = addr_q;
        data_d     = data_q;
        w_byte_d   = 1'b0;
        w_block_d  = w_block_q;
        case (state_q)
            ST_OPEN:  w_block_d = 1'b1;
            ST_HDR: begin
                w_byte_d   = 1'b1;
                data_d     = hdr_byte;
                byte_cnt_d = byte_cnt_q + CW'(1);
            end
            ST_DATA_REQ: if (wr_byte_i) begin
                w_byte_d   = 1'b1;
                data_d     = byte_data_i;
                byte_cnt_d = byte_cnt_q + CW'(1);
                prog_cnt_d = prog_cnt_q + 32'd1;
            end
            ST_PAD: if (!sec_full) begin
                w_byte_d   = 1'b1;
                data_d     = 8'h00;
                byte_cnt_d = byte_cnt_q + CW'(1);
            end
            ST_CLOSE: w_block_d = 1'b0;
            ST_WAIT_CLOSE: if (!spi.spi_busy && !all_sent) begin
                addr_d     = addr_q + 32'd1;
                byte_cnt_d = '0;
            end
            default: ;
        endcase
        if (take_start) begin
            file_len_d = file_len_i;
            addr_d     = begin_address_i + offset_i;
            byte_cnt_d = '0;
            prog_cnt_d = '0;
        end
        if (state_d == ST_ERROR) begin
            w_block_d = 1'b0;
            w_byte_d  = 1'b0;
        end
        busy_d  = !(state_d inside {ST_DATA_REQ, ST_FINISH, ST_ERROR});
        done_d  = (state_d == ST_FINISH);
        error_d = (state_d == ST_ERROR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt_q <= '0;
            prog_cnt_q <= '0;
            file_len_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            w_block_q  <= 1'b0;
            w_byte_q   <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            prog_cnt_q <= prog_cnt_d;
            file_len_q <= file_len_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            w_block_q  <= w_block_d;
            w_byte_q   <= w_byte_d;
        end
    end

    assign busy_o             = busy_q;
    assign done_o             = done_q;
    assign error_o            = error_q;
    assign spi.spi_w_block    = w_block_q;
    assign spi.spi_w_byte     = w_byte_q;
    assign spi.spi_data_in    = data_q;
    assign spi.spi_block_addr = addr_q;

endmodule

// File: tb/tb_write_nanofs.sv
// Bench for write_nanofs: a sector-capturing SD controller model plus a
// reference image built from the on-card format rules.
module tb_write_nanofs;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] offset = '0, begin_addr = '0, file_len = '0;
    logic        wr_byte = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        busy, done, error;
    logic        spi_err_r = 1'b0;
    logic        cap_clr = 1'b0;

    always #5 clk = ~clk;

    write_nanofs_if spi_if();

    write_nanofs dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start),
        .offset_i        (offset),
        .begin_address_i (begin_addr),
        .file_len_i      (file_len),
        .wr_byte_i       (wr_byte),
        .byte_data_i     (byte_data),
        .busy_o          (busy),
        .done_o          (done),
        .error_o         (error),
        .spi             (spi_if)
    );

    // Controller model: busy during every strobe/edge plus 0..3 random extra cycles.
    logic        prev_blk = 1'b0;
    int          busy_cnt = 0;
    int          cur_len = 0;
    logic [31:0] got_addr[$];
    int          got_len[$];
    logic [7:0]  got_bytes[$];

    assign spi_if.spi_busy = (busy_cnt != 0) || spi_if.spi_w_byte || (spi_if.spi_w_block != prev_blk);
    assign spi_if.spi_err  = spi_err_r;

    always @(posedge clk) begin
        prev_blk <= spi_if.spi_w_block;
        if (cap_clr) begin
            got_addr.delete();
            got_len.delete();
            got_bytes.delete();
            cur_len  <= 0;
            busy_cnt <= 0;
        end else begin
            if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
            if (spi_if.spi_w_block && !prev_blk) begin
                got_addr.push_back(spi_if.spi_block_addr);
                busy_cnt <= int'($urandom_range(3, 0));
            end
            if (!spi_if.spi_w_block && prev_blk) begin
                got_len.push_back(cur_len);
                cur_len  <= 0;
                busy_cnt <= int'($urandom_range(3, 0));
            end
            if (spi_if.spi_w_byte) begin
                got_bytes.push_back(spi_if.spi_data_in);
                cur_len  <= cur_len + 1;
                busy_cnt <= int'($urandom_range(3, 0));
            end
        end
    end

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] payload[$];
    logic [7:0] preset[$];

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({busy, done, error} !== 3'b100) begin
            n_fail++; $display("FAIL reset_status: busy/done/error=%b required 100", {busy, done, error});
        end
        n_chk++;
        if (spi_if.spi_w_block !== 1'b0 || spi_if.spi_w_byte !== 1'b0 ||
            spi_if.spi_data_in !== 8'h00 || spi_if.spi_block_addr !== 32'h0) begin
            n_fail++; $display("FAIL reset_spi: blk=%b byte=%b data=%h addr=%h required all zero",
                               spi_if.spi_w_block, spi_if.spi_w_byte, spi_if.spi_data_in, spi_if.spi_block_addr);
        end
        reset = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({busy, done, error, spi_if.spi_w_block} !== 4'b1000) begin
            n_fail++; $display("FAIL idle_after_reset: busy/done/error/blk=%b required 1000",
                               {busy, done, error, spi_if.spi_w_block});
        end
    endtask

    task automatic begin_file(input logic [31:0] bgn, input logic [31:0] off, input logic [31:0] len);
        @(negedge clk); cap_clr = 1'b1;
        @(negedge clk); cap_clr = 1'b0;
        payload.delete();
        for (int i = 0; i < int'(len); i++)
            payload.push_back((i < preset.size()) ? preset[i] : 8'($urandom));
        begin_addr = bgn; offset = off; file_len = len; start = 1'b1;
        @(negedge clk); start = 1'b0;
        n_chk++;
        if (done !== 1'b0 || error !== 1'b0) begin
            n_fail++; $display("FAIL start_clears: done=%b error=%b required 0 0", done, error);
        end
    endtask

    task automatic feed(input int from, input int n, input int gap, input bit noise,
                        output int first_wait, output bit ok);
        ok = 1'b1;
        first_wait = -1;
        for (int i = from; i < from + n; i++) begin
            int cyc;
            cyc = 0;
            while (busy !== 1'b0 && cyc < 5000) begin
                if (noise) begin wr_byte = 1'b1; byte_data = 8'hEE; end
                @(negedge clk);
                wr_byte = 1'b0;
                cyc++;
            end
            if (busy !== 1'b0) begin
                n_chk++; n_fail++;
                $display("FAIL feed_timeout byte %0d: busy=%b after %0d cycles, required 0", i, busy, cyc);
                ok = 1'b0;
                return;
            end
            if (first_wait < 0) first_wait = cyc;
            wr_byte = 1'b1; byte_data = payload[i];
            @(negedge clk);
            wr_byte = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_done(input string nm);
        int cyc;
        bit early;
        cyc = 0; early = 1'b0;
        while (done !== 1'b1 && cyc < 20000) begin
            if (busy === 1'b0) early = 1'b1;
            @(negedge clk);
            cyc++;
        end
        n_chk++;
        if (done !== 1'b1) begin
            n_fail++; $display("FAIL %s done_timeout: done=%b required 1", nm, done);
            return;
        end
        n_chk++;
        if (early) begin
            n_fail++; $display("FAIL %s busy_before_done: busy dropped to 0 required 1 until done", nm);
        end
        n_chk++;
        if (busy !== 1'b0 || spi_if.spi_w_block !== 1'b0 || error !== 1'b0) begin
            n_fail++; $display("FAIL %s finish_outputs: busy=%b blk=%b error=%b required 0 0 0",
                               nm, busy, spi_if.spi_w_block, error);
        end
    endtask

    task automatic check_image(input string nm, input logic [31:0] bgn, input logic [31:0] off,
                               input logic [31:0] len);
        logic [7:0] exp[$];
        int nsec, bad, first;
        for (int k = 0; k < 4; k++) exp.push_back(8'h00);
        for (int k = 0; k < 4; k++) exp.push_back(len[8*k +: 8]);
        foreach (payload[i]) exp.push_back(payload[i]);
        while (exp.size() % 512 != 0) exp.push_back(8'h00);
        nsec = exp.size() / 512;
        n_chk++;
        if (got_addr.size() != nsec || got_len.size() != nsec) begin
            n_fail++; $display("FAIL %s sector_count: opened=%0d closed=%0d required %0d",
                               nm, got_addr.size(), got_len.size(), nsec);
        end
        bad = 0;
        foreach (got_addr[i]) if (got_addr[i] !== bgn + off + 32'(i)) bad++;
        foreach (got_len[i]) if (got_len[i] != 512) bad++;
        n_chk++;
        if (bad != 0) begin
            n_fail++; $display("FAIL %s sector_addr_len: %0d bad sectors (first addr %h), required base %h each 512 bytes",
                               nm, bad, (got_addr.size() > 0) ? got_addr[0] : 32'hx, bgn + off);
        end
        bad = 0; first = -1;
        for (int i = 0; i < exp.size() && i < got_bytes.size(); i++)
            if (got_bytes[i] !== exp[i]) begin bad++; if (first < 0) first = i; end
        n_chk++;
        if (got_bytes.size() != exp.size() || bad != 0) begin
            n_fail++;
            if (first >= 0)
                $display("FAIL %s image: %0d bytes differ, byte %0d is %h required %h", nm, bad, first,
                         got_bytes[first], exp[first]);
            else
                $display("FAIL %s image: %0d bytes written required %0d", nm, got_bytes.size(), exp.size());
        end
    endtask

    task automatic run_file(input string nm, input logic [31:0] bgn, input logic [31:0] off,
                            input logic [31:0] len, input int gap, input bit noise);
        int fw;
        bit ok;
        begin_file(bgn, off, len);
        feed(0, int'(len), gap, noise, fw, ok);
        if (!ok) return;
        if (len != 0) begin
            n_chk++;
            if (fw < 12) begin
                n_fail++; $display("FAIL %s first_req_latency: %0d cycles required >= 12", nm, fw);
            end
        end
        wait_done(nm);
        check_image(nm, bgn, off, len);
    endtask

    task automatic test_example();
        preset = '{8'hA1, 8'hA2, 8'hA3};
        run_file("example", 32'h10, 32'h100, 32'd3, 0, 1'b0);
        preset.delete();
        n_chk++;
        if (got_addr.size() < 1 || got_addr[0] !== 32'h110) begin
            n_fail++; $display("FAIL example_addr: sector %h required 00000110",
                               (got_addr.size() > 0) ? got_addr[0] : 32'hx);
        end
    endtask

    task automatic test_boundary();
        run_file("len504", 32'h200, 32'h0, 32'd504, 0, 1'b0);
        run_file("len505", 32'h300, 32'h7, 32'd505, 0, 1'b1);
        run_file("len0", 32'h40, 32'h4, 32'd0, 0, 1'b0);
    endtask

    task automatic test_spi_error();
        int fw;
        bit ok;
        begin_file(32'h30, 32'h1000, 32'd10);
        feed(0, 3, 0, 1'b0, fw, ok);
        spi_err_r = 1'b1;
        @(negedge clk);
        spi_err_r = 1'b0;
        n_chk++;
        if (error !== 1'b1 || spi_if.spi_w_block !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL spi_err_reaction: error=%b blk=%b busy=%b done=%b required 1 0 0 0",
                               error, spi_if.spi_w_block, busy, done);
        end
        repeat (3) @(negedge clk);
        n_chk++;
        if (error !== 1'b1) begin
            n_fail++; $display("FAIL error_sticky: error=%b required 1", error);
        end
        run_file("after_error", 32'h30, 32'h1000, 32'd10, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        int fw;
        bit ok;
        int bad;
        begin_file(32'h20, 32'h40, 32'd600);
        feed(0, 520, 0, 1'b0, fw, ok);
        reset = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({busy, done, error} !== 3'b100) begin
            n_fail++; $display("FAIL reset_mid_status: busy/done/error=%b required 100", {busy, done, error});
        end
        n_chk++;
        if (spi_if.spi_w_block !== 1'b0 || spi_if.spi_w_byte !== 1'b0 ||
            spi_if.spi_data_in !== 8'h00 || spi_if.spi_block_addr !== 32'h0) begin
            n_fail++; $display("FAIL reset_mid_spi: blk=%b byte=%b data=%h addr=%h required all zero",
                               spi_if.spi_w_block, spi_if.spi_w_byte, spi_if.spi_data_in, spi_if.spi_block_addr);
        end
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            wr_byte = 1'b1; byte_data = 8'h5A;
            @(negedge clk);
            if (busy !== 1'b1 || spi_if.spi_w_byte !== 1'b0) bad++;
        end
        wr_byte = 1'b0;
        n_chk++;
        if (bad != 0) begin
            n_fail++; $display("FAIL idle_ignores_wr_byte: %0d cycles with busy=0 or byte strobe, required 0", bad);
        end
        run_file("after_reset", 32'h20, 32'h40, 32'd40, 0, 1'b1);
    endtask

    task automatic test_wrap_and_slow();
        run_file("wrap", 32'h1, 32'hFFFF_FFFF, 32'd5, 0, 1'b0);
        n_chk++;
        if (got_addr.size() < 1 || got_addr[0] !== 32'h0) begin
            n_fail++; $display("FAIL wrap_addr: sector %h required 00000000",
                               (got_addr.size() > 0) ? got_addr[0] : 32'hx);
        end
        run_file("slow", 32'h500, 32'h10, 32'd12, 50, 1'b1);
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            run_file("random", $urandom, $urandom, 32'($urandom_range(600, 1)),
                     int'($urandom_range(2, 0)), 1'($urandom_range(1, 0)));
        end
    endtask

    initial begin
        test_reset();
        test_example();
        test_boundary();
        test_spi_error();
        test_reset_mid();
        test_wrap_and_slow();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
